seq_detector_prog: RTL and testbench

- Runtime-programmable serial bit-pattern detector with Moore-style registered output. It is the parametrised successor of the fixed 4-bit "1011" detector.
- Pattern length is up to MAX_LEN bits. Overlapping or non-overlapping detection is selectable.
- Input is gated by a per-bit valid, and detections are tallied in a saturating match counter.
- Sits between a serial line receiver and the control/status logic. Resets to the legacy "1011", overlapping configuration.

---
 rtl/seq_det_pkg.sv | 20 ++
 rtl/seq_detector_prog_if.sv | 42 ++++
 rtl/seq_det_match_counter.sv | 31 +++
 rtl/seq_detector_prog.sv | 103 ++++++++++
 tb/tb_seq_detector_prog.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_det_pkg.sv
// Shared definitions for the programmable serial pattern detector.
//   state_t      : RUN / PAUSED control states
//   DEF_*        : configuration restored by reset (legacy "1011", overlapping)
//   len_w()      : width needed to hold a length value 0..max_len
package seq_det_pkg;

  typedef enum logic {
    RUN    = 1'b0,
    PAUSED = 1'b1
  } state_t;

  localparam logic [7:0] DEF_PATTERN = 8'b0000_1011;
  localparam int         DEF_LEN     = 4;
  localparam bit         DEF_OVERLAP = 1'b1;

  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/seq_detector_prog_if.sv
// Signal bundle between the serial receiver / control logic (master) and
// the pattern detector (slave).
//   cfg_load/cfg_pattern/cfg_len/cfg_overlap : configuration strobe + fields
//   cfg_err                                  : rejected-load pulse
//   enable/in_valid/sequence_in              : serial input stream
//   cnt_clr                                  : synchronous counter clear
//   detector_out/match_count/paused          : registered status
//   dbg_state                                : current control state
// Strobe semantics: cfg_load and in_valid are single-cycle qualifiers sampled
// on the rising clock edge; there is no back-pressure, the detector always
// accepts what is qualified.
interface seq_detector_prog_if #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = seq_det_pkg::len_w(MAX_LEN),
  parameter int CNT_W   = 16
);
  logic                 cfg_load;
  logic [MAX_LEN-1:0]   cfg_pattern;
  logic [LEN_W-1:0]     cfg_len;
  logic                 cfg_overlap;
  logic                 cfg_err;
  logic                 enable;
  logic                 in_valid;
  logic                 sequence_in;
  logic                 detector_out;
  logic [CNT_W-1:0]     match_count;
  logic                 cnt_clr;
  logic                 paused;
  seq_det_pkg::state_t  dbg_state;

  modport master (
    output cfg_load, cfg_pattern, cfg_len, cfg_overlap, enable, in_valid,
           sequence_in, cnt_clr,
    input  cfg_err, detector_out, match_count, paused, dbg_state
  );

  modport slave (
    input  cfg_load, cfg_pattern, cfg_len, cfg_overlap, enable, in_valid,
           sequence_in, cnt_clr,
    output cfg_err, detector_out, match_count, paused, dbg_state
  );
endinterface

// File: rtl/seq_det_match_counter.sv
// Saturating event counter.
//   clock, reset : rising-edge clock, async active-high reset
//   i_inc        : count one event this cycle
//   i_clr        : synchronous clear; an event in the same cycle still counts,
//                  leaving the counter at 1
//   o_count      : current count, sticks at all-ones
module seq_det_match_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= i_inc ? CNT_W'(1) : '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial bit-pattern detector, Moore-style output.
//   clock, reset : rising-edge clock, async active-high reset
//   bus          : slave side of seq_detector_prog_if (config, serial input,
//                  counter clear, registered status and debug state)
// A bit is shifted into the history when qualified and the detector is
// running; a match raises detector_out on the following cycle and bumps the
// saturating match counter.
module seq_detector_prog #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 LEN_W       = seq_det_pkg::len_w(MAX_LEN),
  parameter int                 CNT_W       = 16,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(seq_det_pkg::DEF_PATTERN),
  parameter logic [LEN_W-1:0]   DEF_LEN     = LEN_W'(seq_det_pkg::DEF_LEN),
  parameter logic               DEF_OVERLAP = seq_det_pkg::DEF_OVERLAP
) (
  input  logic                clock,
  input  logic                reset,
  seq_detector_prog_if.slave  bus
);
  import seq_det_pkg::*;

  state_t             r_state, w_state_next;
  logic [MAX_LEN-1:0] r_pattern, r_hist, w_hist_next, w_mask;
  logic [LEN_W-1:0]   r_len, r_fill, w_fill_next;
  logic               r_overlap, r_det, r_err, r_paused;
  logic               w_cfg_ok, w_accept, w_match;

  // Control FSM: state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= RUN;
    else       r_state <= w_state_next;
  end

  // Control FSM: next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RUN:     if (!bus.enable) w_state_next = PAUSED;
      PAUSED:  if (bus.enable)  w_state_next = RUN;
      default: w_state_next = RUN;
    endcase
  end

  assign w_cfg_ok = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_W'(MAX_LEN));
  // A load in the same cycle always wins over the data bit.
  assign w_accept = bus.in_valid && bus.enable && (r_state == RUN) && !bus.cfg_load;

  always_comb begin
    w_hist_next = {r_hist[MAX_LEN-2:0], bus.sequence_in};
    w_fill_next = (r_fill >= r_len) ? r_len : r_fill + LEN_W'(1);
    w_mask      = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (i < int'(r_len));
    end
    // Only the low len bits take part; upper pattern bits are don't-care.
    w_match = w_accept && (w_fill_next >= r_len) &&
              (((w_hist_next ^ r_pattern) & w_mask) == '0);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pattern <= DEF_PATTERN;
      r_len     <= DEF_LEN;
      r_overlap <= DEF_OVERLAP;
      r_hist    <= '0;
      r_fill    <= '0;
      r_det     <= 1'b0;
      r_err     <= 1'b0;
      r_paused  <= 1'b0;
    end else begin
      r_det    <= w_match;
      r_paused <= (w_state_next == PAUSED);
      r_err    <= bus.cfg_load && !w_cfg_ok;
      if (bus.cfg_load) begin
        if (w_cfg_ok) begin
          r_pattern <= bus.cfg_pattern;
          r_len     <= bus.cfg_len;
          r_overlap <= bus.cfg_overlap;
          r_hist    <= '0;
          r_fill    <= '0;
        end
      end else if (w_accept) begin
        r_hist <= w_hist_next;
        // Non-overlapping mode restarts the fill so a whole new pattern is needed.
        r_fill <= (w_match && !r_overlap) ? '0 : w_fill_next;
      end
    end
  end

  seq_det_match_counter #(.CNT_W(CNT_W)) u_cnt (
    .clock   (clock),
    .reset   (reset),
    .i_inc   (w_match),
    .i_clr   (bus.cnt_clr),
    .o_count (bus.match_count)
  );

  assign bus.detector_out = r_det;
  assign bus.cfg_err      = r_err;
  assign bus.paused       = r_paused;
  assign bus.dbg_state    = r_state;

endmodule

// File: tb/tb_seq_detector_prog.sv
// Bench for seq_detector_prog: a 16-bit-counter instance and a 2-bit-counter
// instance driven with identical stimulus, checked every cycle against a
// bit-queue model plus hand-computed literal expectations.
module tb_seq_detector_prog;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic       drv_cfg_load = 1'b0;
  logic [7:0] drv_cfg_pattern = 8'h00;
  logic [3:0] drv_cfg_len = 4'd0;
  logic       drv_cfg_overlap = 1'b0;
  logic       drv_enable = 1'b1;
  logic       drv_in_valid = 1'b0;
  logic       drv_seq = 1'b0;
  logic       drv_cnt_clr = 1'b0;

  seq_detector_prog_if #(.MAX_LEN(8), .CNT_W(16)) bus1 ();
  seq_detector_prog_if #(.MAX_LEN(8), .CNT_W(2))  bus2 ();

  assign bus1.cfg_load    = drv_cfg_load;
  assign bus1.cfg_pattern = drv_cfg_pattern;
  assign bus1.cfg_len     = drv_cfg_len;
  assign bus1.cfg_overlap = drv_cfg_overlap;
  assign bus1.enable      = drv_enable;
  assign bus1.in_valid    = drv_in_valid;
  assign bus1.sequence_in = drv_seq;
  assign bus1.cnt_clr     = drv_cnt_clr;
  assign bus2.cfg_load    = drv_cfg_load;
  assign bus2.cfg_pattern = drv_cfg_pattern;
  assign bus2.cfg_len     = drv_cfg_len;
  assign bus2.cfg_overlap = drv_cfg_overlap;
  assign bus2.enable      = drv_enable;
  assign bus2.in_valid    = drv_in_valid;
  assign bus2.sequence_in = drv_seq;
  assign bus2.cnt_clr     = drv_cnt_clr;

  seq_detector_prog #(.MAX_LEN(8), .CNT_W(16)) dut  (.clock(clock), .reset(reset), .bus(bus1));
  seq_detector_prog #(.MAX_LEN(8), .CNT_W(2))  dut2 (.clock(clock), .reset(reset), .bus(bus2));

  int checks = 0;
  int errors = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0b required=%0b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        hist_q[$];
  logic [7:0]  m_pat;
  int          m_len;
  logic        m_ov;
  int          m_avail;
  logic        m_run;
  logic        m_acc, m_hit;
  logic        exp_det, exp_err, exp_paused;
  logic [15:0] exp_cnt16;
  logic [1:0]  exp_cnt2;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_pat = 8'b0000_1011; m_len = 4; m_ov = 1'b1;
      hist_q.delete(); m_avail = 0; m_run = 1'b1;
      exp_det = 1'b0; exp_err = 1'b0; exp_paused = 1'b0;
      exp_cnt16 = 16'd0; exp_cnt2 = 2'd0;
    end else begin
      m_acc = drv_in_valid && drv_enable && m_run && !drv_cfg_load;
      m_hit = 1'b0;
      exp_err = 1'b0;
      if (drv_cfg_load) begin
        if (drv_cfg_len >= 4'd1 && drv_cfg_len <= 4'd8) begin
          m_pat = drv_cfg_pattern; m_len = int'(drv_cfg_len); m_ov = drv_cfg_overlap;
          hist_q.delete(); m_avail = 0;
        end else begin
          exp_err = 1'b1;
        end
      end
      if (m_acc) begin
        hist_q.push_back(drv_seq);
        if (hist_q.size() > 8) void'(hist_q.pop_front());
        m_avail++;
        if (m_avail >= m_len) begin
          m_hit = 1'b1;
          for (int k = 0; k < m_len; k++)
            if (hist_q[hist_q.size()-1-k] != m_pat[k]) m_hit = 1'b0;
        end
        if (m_hit && !m_ov) m_avail = 0;
      end
      exp_det = m_hit;
      if (drv_cnt_clr) begin
        exp_cnt16 = m_hit ? 16'd1 : 16'd0;
        exp_cnt2  = m_hit ? 2'd1 : 2'd0;
      end else if (m_hit) begin
        if (exp_cnt16 != 16'hFFFF) exp_cnt16 = exp_cnt16 + 16'd1;
        if (exp_cnt2 != 2'd3)      exp_cnt2  = exp_cnt2 + 2'd1;
      end
      m_run = drv_enable;
      exp_paused = !drv_enable;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clock) begin
    if (!reset) begin
      chk1("det", bus1.detector_out, exp_det);
      chk1("det2", bus2.detector_out, exp_det);
      chk1("cfg_err", bus1.cfg_err, exp_err);
      chk1("paused", bus1.paused, exp_paused);
      chk16("count16", bus1.match_count, exp_cnt16);
      chk16("count2", 16'(bus2.match_count), 16'(exp_cnt2));
    end
  end

  // ---------------- driver tasks ----------------
  // One cycle of stream input, then a literal check on detector_out after the edge.
  task automatic send(input logic v, input logic b, input logic exp_d, input logic clr);
    @(negedge clock);
    drv_cfg_load = 1'b0; drv_cnt_clr = clr; drv_enable = 1'b1;
    drv_in_valid = v; drv_seq = b;
    @(posedge clock); #1;
    chk1("lit_det", bus1.detector_out, exp_d);
  endtask

  task automatic send_bits(input logic [7:0] bits, input int n, input logic [7:0] exp_d);
    for (int i = n - 1; i >= 0; i--) send(1'b1, bits[i], exp_d[i], 1'b0);
  endtask

  task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ov, input logic exp_e);
    @(negedge clock);
    drv_cfg_load = 1'b1; drv_cfg_pattern = pat; drv_cfg_len = len; drv_cfg_overlap = ov;
    drv_cnt_clr = 1'b0; drv_in_valid = 1'b1; drv_seq = 1'b1;
    @(posedge clock); #1;
    chk1("lit_cfg_err", bus1.cfg_err, exp_e);
  endtask

  task automatic clear_cnt();
    @(negedge clock);
    drv_cfg_load = 1'b0; drv_cnt_clr = 1'b1; drv_in_valid = 1'b0;
    @(posedge clock); #1;
    chk16("lit_clr", bus1.match_count, 16'd0);
  endtask

  task automatic pause(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      drv_cfg_load = 1'b0; drv_cnt_clr = 1'b0; drv_enable = 1'b0;
      drv_in_valid = 1'b1; drv_seq = 1'($urandom_range(0, 1));
      @(posedge clock); #1;
      chk1("lit_paused", bus1.paused, 1'b1);
      chk1("lit_det_paused", bus1.detector_out, 1'b0);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; drv_cfg_load = 1'b0; drv_cnt_clr = 1'b0;
    drv_in_valid = 1'b0; drv_enable = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk1("rst_det", bus1.detector_out, 1'b0);
    chk1("rst_err", bus1.cfg_err, 1'b0);
    chk1("rst_paused", bus1.paused, 1'b0);
    chk16("rst_count", bus1.match_count, 16'd0);
  endtask

  initial begin
    do_reset();

    // Default overlapping 1011: 1,0,1,1,0,1,1 -> pulses after bits 4 and 7
    send_bits(8'b0101_1011, 7, 8'b0000_1001);
    chk16("t1_count", bus1.match_count, 16'd2);

    // Non-overlapping 1011: 1011011 -> single pulse
    clear_cnt();
    load(8'b0000_1011, 4'd4, 1'b0, 1'b0);
    send_bits(8'b0101_1011, 7, 8'b0000_1000);
    chk16("t2_count", bus1.match_count, 16'd1);

    // Illegal lengths rejected, default config survives
    do_reset();
    load(8'hFF, 4'd0, 1'b0, 1'b1);
    load(8'hFF, 4'd9, 1'b0, 1'b1);
    send_bits(8'b0000_1011, 4, 8'b0000_0001);
    chk16("t3_count", bus1.match_count, 16'd1);

    // 8-bit pattern with gaps and a 3-cycle pause
    load(8'b1100_1010, 4'd8, 1'b1, 1'b0);
    send(1'b1, 1'b1, 1'b0, 1'b0);
    send(1'b0, 1'b0, 1'b0, 1'b0);
    send(1'b1, 1'b1, 1'b0, 1'b0);
    send(1'b1, 1'b0, 1'b0, 1'b0);
    send(1'b1, 1'b0, 1'b0, 1'b0);
    pause(3);
    send(1'b1, 1'b1, 1'b0, 1'b0);  // still PAUSED on this edge: bit ignored
    chk1("lit_resumed", bus1.paused, 1'b0);
    send(1'b1, 1'b1, 1'b0, 1'b0);
    send(1'b0, 1'b1, 1'b0, 1'b0);
    send(1'b1, 1'b0, 1'b0, 1'b0);
    send(1'b1, 1'b1, 1'b0, 1'b0);
    send(1'b1, 1'b0, 1'b1, 1'b0);
    send(1'b0, 1'b0, 1'b0, 1'b0);
    chk16("t4_count", bus1.match_count, 16'd2);

    // Saturation on the 2-bit counter, clear-with-match
    do_reset();
    send_bits(8'b0000_1011, 4, 8'b0000_0001);
    for (int i = 0; i < 4; i++) send_bits(8'b0000_0011, 3, 8'b0000_0001);
    chk16("t5_count16", bus1.match_count, 16'd5);
    chk16("t5_count2_sat", 16'(bus2.match_count), 16'd3);
    send(1'b1, 1'b0, 1'b0, 1'b0);
    send(1'b1, 1'b1, 1'b0, 1'b0);
    send(1'b1, 1'b1, 1'b1, 1'b1);
    chk16("t5_clr_hit16", bus1.match_count, 16'd1);
    chk16("t5_clr_hit2", 16'(bus2.match_count), 16'd1);
    clear_cnt();

    // Reset mid-pattern aborts the partial match
    do_reset();
    send_bits(8'b0000_0101, 3, 8'b0000_0000);
    do_reset();
    send(1'b1, 1'b1, 1'b0, 1'b0);
    chk16("t6_count", bus1.match_count, 16'd0);

    send(1'b0, 1'b0, 1'b0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
